// File: rtl/diff_freq_serial_in_pkg.sv
// Shared definitions for the differential-frequency serial link: receiver FSM
// encoding and the default prescaler divisors also used by the transmitter.
package diff_freq_serial_in_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } rx_state_e;

  localparam int unsigned LOW_DIV  = 63;
  localparam int unsigned HIGH_DIV = 31;

  // Prescaler width; divisors must not exceed 2**PSC_W.
  localparam int unsigned PSC_W = 8;

endpackage

// File: rtl/diff_freq_serial_in_rx_tick_gen.sv
// Selectable-divisor prescaler: counts 0..DIV-1 and emits a one-cycle tick on
// DIV-1. The divisor select is latched on i_load; i_clr holds the count at 0.
module rx_tick_gen #(
  parameter int unsigned LOW_DIV  = diff_freq_serial_in_pkg::LOW_DIV,
  parameter int unsigned HIGH_DIV = diff_freq_serial_in_pkg::HIGH_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_sel,
  output logic o_tick
);
  import diff_freq_serial_in_pkg::*;

  localparam logic [PSC_W-1:0] LOW_LAST  = PSC_W'(LOW_DIV - 1);
  localparam logic [PSC_W-1:0] HIGH_LAST = PSC_W'(HIGH_DIV - 1);

  logic [PSC_W-1:0] psc_q, psc_d;
  logic             sel_q, sel_d;
  logic [PSC_W-1:0] psc_last;

  always_comb begin
    sel_d    = i_load ? i_sel : sel_q;
    psc_last = sel_q ? HIGH_LAST : LOW_LAST;
    o_tick   = !i_clr && (psc_q == psc_last);
    psc_d    = (i_clr || o_tick) ? '0 : psc_q + PSC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
      sel_q <= 1'b0;
    end else begin
      psc_q <= psc_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/diff_freq_serial_in.sv
// Oversampling serial receiver (LSB first) with two selectable bit rates.
// Optional macro DIFF_FREQ_RX_MAJORITY_EN: 2-of-3 vote around mid-bit.
module diff_freq_serial_in #(
  parameter int unsigned DATA_BIT     = 16,
  parameter int unsigned TICK_PER_BIT = 16,
  parameter int unsigned LOW_DIV      = diff_freq_serial_in_pkg::LOW_DIV,
  parameter int unsigned HIGH_DIV     = diff_freq_serial_in_pkg::HIGH_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sel_freq,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_continuous,
  input  logic                i_data,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_done_tick,
  output logic                o_busy
);
  import diff_freq_serial_in_pkg::*;

  localparam int unsigned T_W = $clog2(TICK_PER_BIT);
  localparam int unsigned B_W = $clog2(DATA_BIT);
  localparam logic [T_W-1:0] T_LAST = T_W'(TICK_PER_BIT - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BIT - 1);
`ifdef DIFF_FREQ_RX_MAJORITY_EN
  localparam logic [T_W-1:0] T_VOTE0  = T_W'(TICK_PER_BIT / 2 - 2);
  localparam logic [T_W-1:0] T_VOTE1  = T_W'(TICK_PER_BIT / 2 - 1);
  localparam logic [T_W-1:0] T_COMMIT = T_W'(TICK_PER_BIT / 2);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`else
  localparam logic [T_W-1:0] T_COMMIT = T_W'(TICK_PER_BIT / 2 - 1);
`endif

  rx_state_e           state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [B_W-1:0]      b_q, b_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                wend_q, wend_d;
  logic                cont_q, cont_d;
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                done_q, done_d;
`ifdef DIFF_FREQ_RX_MAJORITY_EN
  logic                vote0_q, vote0_d;
  logic                vote1_q, vote1_d;
`endif

  logic accept;
  logic tick;
  logic tick_clr;
  logic rx_bit;

  assign tick_clr = (state_q == ST_IDLE);

  rx_tick_gen #(
    .LOW_DIV  (LOW_DIV),
    .HIGH_DIV (HIGH_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (tick_clr),
    .i_load (accept),
    .i_sel  (i_sel_freq),
    .o_tick (tick)
  );

  always_comb begin
    sync1_d = i_data;
    sync2_d = sync1_q;
    state_d = state_q;
    t_d     = t_q;
    b_d     = b_q;
    shift_d = shift_q;
    wend_d  = 1'b0;
    cont_d  = cont_q;
    data_d  = data_q;
    done_d  = 1'b0;
    accept  = (state_q == ST_IDLE) && i_start && !i_stop;
`ifdef DIFF_FREQ_RX_MAJORITY_EN
    vote0_d = vote0_q;
    vote1_d = vote1_q;
    rx_bit  = maj3(vote0_q, vote1_q, sync2_q);
`else
    rx_bit  = sync2_q;
`endif

    // A completed word is published one clock after its last sample.
    if (wend_q) begin
      data_d = shift_q;
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RECV;
          t_d     = '0;
          b_d     = '0;
          shift_d = '0;
        end
      end
      ST_RECV: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else begin
          if (wend_q && !cont_q) begin
            state_d = ST_IDLE;
          end
          if (tick) begin
            t_d = (t_q == T_LAST) ? '0 : t_q + T_W'(1);
            if (t_q == T_LAST) begin
              b_d = (b_q == B_LAST) ? '0 : b_q + B_W'(1);
            end
`ifdef DIFF_FREQ_RX_MAJORITY_EN
            if (t_q == T_VOTE0) vote0_d = sync2_q;
            if (t_q == T_VOTE1) vote1_d = sync2_q;
`endif
            if (t_q == T_COMMIT) begin
              shift_d = {rx_bit, shift_q[DATA_BIT-1:1]};
              if (b_q == B_LAST) begin
                wend_d = 1'b1;
                cont_d = i_continuous;
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      t_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      wend_q  <= 1'b0;
      cont_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef DIFF_FREQ_RX_MAJORITY_EN
      vote0_q <= 1'b0;
      vote1_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      t_q     <= t_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      wend_q  <= wend_d;
      cont_q  <= cont_d;
      data_q  <= data_d;
      done_q  <= done_d;
`ifdef DIFF_FREQ_RX_MAJORITY_EN
      vote0_q <= vote0_d;
      vote1_q <= vote1_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_done_tick = done_q;
  assign o_busy      = (state_q == ST_RECV);

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in: cycle numbers count from the edge
// that accepts i_start, and the serial line is generated from that count.
module tb_diff_freq_serial_in;

`ifdef DIFF_FREQ_RX_MAJORITY_EN
  localparam int          EXTRA_L    = 63;
  localparam int          EXTRA_H    = 31;
  localparam logic [15:0] GLITCH_EXP = 16'hFFFF;
`else
  localparam int          EXTRA_L    = 0;
  localparam int          EXTRA_H    = 0;
  localparam logic [15:0] GLITCH_EXP = 16'hFFF7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_sel_freq = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_continuous = 1'b0;
  logic        i_data;
  logic [15:0] o_data;
  logic        o_done_tick;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  logic        tx_on = 1'b0;
  int          bitlen = 1008;
  logic [15:0] w0 = 16'h0000;
  logic [15:0] w1 = 16'h0000;
  int          glo = -1;
  int          ghi = -1;

  diff_freq_serial_in dut (
    .clk          (clk),
    .rst          (rst),
    .i_sel_freq   (i_sel_freq),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_continuous (i_continuous),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_done_tick  (o_done_tick),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= i_start ? 0 : cyc + 1;

  function automatic logic tx_level(input int c, input logic on, input int bl,
                                    input logic [15:0] a, input logic [15:0] b,
                                    input int gl, input int gh);
    int wi;
    int bi;
    logic [15:0] w;
    if (!on) return 1'b1;
    if (c >= gl && c < gh) return 1'b0;
    wi = c / (16 * bl);
    bi = (c / bl) % 16;
    w  = (wi == 0) ? a : b;
    return w[bi];
  endfunction

  assign i_data = tx_level(cyc, tx_on, bitlen, w0, w1, glo, ghi);

  task automatic start_rx(input logic sel, input logic cont);
    @(negedge clk);
    i_sel_freq   = sel;
    i_continuous = cont;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic watch_done(input int until_cyc, output int at,
                            output logic [15:0] d, output int n);
    at = -1;
    d  = '0;
    n  = 0;
    while (cyc < until_cyc) begin
      @(negedge clk);
      if (o_done_tick === 1'b1) begin
        if (n == 0) begin
          at = cyc;
          d  = o_data;
        end
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_o_data: got %h expected 0000", o_data);
    end
    checks++;
    if (o_done_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b expected 0", o_done_tick);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_low();
    int at, n;
    logic [15:0] d;
    tx_on = 1'b1; bitlen = 1008; w0 = 16'hA5C3; w1 = 16'hA5C3; glo = -1; ghi = -1;
    start_rx(1'b0, 1'b0);
    wait_cyc(1);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL low_busy_rise: got %b expected 1", o_busy);
    end
    watch_done(16000, at, d, n);
    checks++;
    if (at != 15625 + EXTRA_L) begin
      failures++;
      $display("FAIL low_done_cycle: got %0d expected %0d", at, 15625 + EXTRA_L);
    end
    checks++;
    if (d !== 16'hA5C3) begin
      failures++;
      $display("FAIL low_data: got %h expected a5c3", d);
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL low_done_count: got %0d expected 1", n);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL low_busy_fall: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_abort();
    int at, n;
    logic [15:0] d;
    tx_on = 1'b1; bitlen = 1008; w0 = 16'h0F0F; w1 = 16'h0F0F; glo = -1; ghi = -1;
    start_rx(1'b0, 1'b0);
    wait_cyc(6000);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b expected 0", o_busy);
    end
    watch_done(6500, at, d, n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d pulses expected 0", n);
    end
    checks++;
    if (o_data !== 16'hA5C3) begin
      failures++;
      $display("FAIL abort_o_data: got %h expected a5c3", o_data);
    end
  endtask

  task automatic test_start_stop_same();
    @(negedge clk);
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop  = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_busy: got %b expected 0", o_busy);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done_tick !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_idle: got busy=%b done=%b expected 0 0", o_busy, o_done_tick);
    end
  endtask

  task automatic test_single_high();
    int at, n;
    logic [15:0] d;
    tx_on = 1'b1; bitlen = 496; w0 = 16'h0001; w1 = 16'h0001; glo = -1; ghi = -1;
    start_rx(1'b1, 1'b0);
    watch_done(8500, at, d, n);
    checks++;
    if (at != 7689 + EXTRA_H) begin
      failures++;
      $display("FAIL high_done_cycle: got %0d expected %0d", at, 7689 + EXTRA_H);
    end
    checks++;
    if (d !== 16'h0001 || n != 1) begin
      failures++;
      $display("FAIL high_data: got %h (%0d pulses) expected 0001 (1 pulse)", d, n);
    end
  endtask

  task automatic test_continuous();
    int at, n;
    logic [15:0] d;
    tx_on = 1'b1; bitlen = 1008; w0 = 16'h1234; w1 = 16'hBEEF; glo = -1; ghi = -1;
    start_rx(1'b0, 1'b1);
    watch_done(16000, at, d, n);
    checks++;
    if (at != 15625 + EXTRA_L || d !== 16'h1234) begin
      failures++;
      $display("FAIL cont_word0: got cycle %0d data %h expected cycle %0d data 1234",
               at, d, 15625 + EXTRA_L);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL cont_busy_between: got %b expected 1", o_busy);
    end
    i_continuous = 1'b0;
    watch_done(32500, at, d, n);
    checks++;
    if (at != 31753 + EXTRA_L || d !== 16'hBEEF) begin
      failures++;
      $display("FAIL cont_word1: got cycle %0d data %h expected cycle %0d data beef",
               at, d, 31753 + EXTRA_L);
    end
    checks++;
    if (o_busy !== 1'b0 || n != 1) begin
      failures++;
      $display("FAIL cont_end_idle: got busy=%b pulses=%0d expected 0 1", o_busy, n);
    end
  endtask

  task automatic test_glitch();
    int at, n;
    logic [15:0] d;
    // Bit 3 mid-bit tick lands on clock (3*16+8)*31 = 1736; the synchronized
    // value used there is the line level three cycles earlier.
    tx_on = 1'b1; bitlen = 496; w0 = 16'hFFFF; w1 = 16'hFFFF;
    glo = 1736 - 3 - 15; ghi = 1736 - 3 + 16;
    start_rx(1'b1, 1'b0);
    watch_done(8500, at, d, n);
    checks++;
    if (d !== GLITCH_EXP || at != 7689 + EXTRA_H) begin
      failures++;
      $display("FAIL glitch_word: got %h at %0d expected %h at %0d",
               d, at, GLITCH_EXP, 7689 + EXTRA_H);
    end
    glo = -1; ghi = -1;
  endtask

  task automatic test_reset_midframe();
    int at, n;
    logic [15:0] d;
    tx_on = 1'b1; bitlen = 1008; w0 = 16'hFFFF; w1 = 16'hFFFF; glo = -1; ghi = -1;
    start_rx(1'b0, 1'b0);
    wait_cyc(5000);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_data !== 16'h0000 || o_done_tick !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: got busy=%b data=%h done=%b expected 0 0000 0",
               o_busy, o_data, o_done_tick);
    end
    rst = 1'b0;
    watch_done(6000, at, d, n);
    checks++;
    if (n != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: got pulses=%0d busy=%b expected 0 0", n, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_low();
    test_abort();
    test_start_stop_same();
    test_single_high();
    test_continuous();
    test_glitch();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
